// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter/encoder.
package rr_arb_pkg;

    localparam int unsigned EncodeWidthDefault = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req starting at start, wrapping at
// decode_width. found is low when req is all zero.
module rr_pick #(
    parameter int unsigned encode_width = 4,
    parameter int unsigned decode_width = (1 << encode_width)
) (
    input  logic [decode_width-1:0] req,
    input  logic [encode_width-1:0] start,
    output logic                    found,
    output logic [encode_width-1:0] idx
);

    localparam int unsigned SumW = encode_width + 1;

    logic [2*decode_width-1:0] req_dbl;
    logic [decode_width-1:0]   req_rot;
    logic [SumW-1:0]           off;
    logic [SumW-1:0]           sum;

    always_comb begin
        // Rotate so that bit 0 of req_rot corresponds to requester start.
        req_dbl = {req, req} >> start;
        req_rot = req_dbl[decode_width-1:0];
        found   = |req_rot;
        off     = '0;
        for (int j = int'(decode_width) - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                off = SumW'(j);
            end
        end
        sum = {1'b0, start} + off;
        if (sum >= SumW'(decode_width)) begin
            sum = sum - SumW'(decode_width);
        end
        idx = sum[encode_width-1:0];
    end

endmodule

// File: rtl/rr_arb_encoder.sv
// Round-robin arbiter producing a binary grant index with a valid/ready handshake.
// Optional 16-bit handshake counter enabled by defining RR_ARB_GRANT_CNT_EN.
module rr_arb_encoder
    import rr_arb_pkg::*;
#(
    parameter int unsigned encode_width = EncodeWidthDefault,
    parameter int unsigned decode_width = (1 << encode_width)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [decode_width-1:0] req,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [encode_width-1:0] out_idx
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]             grant_cnt
`endif
);

    arb_state_e              state_q, state_d;
    logic [encode_width-1:0] ptr_q, ptr_d;
    logic [encode_width-1:0] idx_q, idx_d;
    logic [encode_width-1:0] ptr_inc;
    logic [encode_width-1:0] pick_start;
    logic [encode_width-1:0] pick_idx;
    logic                    pick_found;
    logic                    handshake;

    // On a handshake the next search must already start past the current grant.
    assign ptr_inc    = (idx_q == encode_width'(decode_width - 1)) ? '0
                                                                   : idx_q + encode_width'(1);
    assign pick_start = (state_q == GRANT) ? ptr_inc : ptr_q;
    assign handshake  = (state_q == GRANT) && out_ready;

    rr_pick #(
        .encode_width(encode_width),
        .decode_width(decode_width)
    ) u_pick (
        .req  (req),
        .start(pick_start),
        .found(pick_found),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (handshake) begin
                    ptr_d = ptr_inc;
                    if (pick_found) begin
                        idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = (state_q == GRANT);
    assign out_idx   = idx_q;

`ifdef RR_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (handshake) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_encoder.sv
// Directed self-checking bench for rr_arb_encoder (default 16 requesters).
module tb_rr_arb_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_idx;
`ifdef RR_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arb_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_idx  (out_idx)
`ifdef RR_ARB_GRANT_CNT_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    // Advance one edge and settle before sampling / driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 16'h0000; out_ready = 1'b0;
        step(); step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b idx=%0d, required valid=0 idx=0", out_valid, out_idx);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || out_idx !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_no_req[%0d]: valid=%b idx=%0d, required valid=0 idx=0",
                         i, out_valid, out_idx);
            end
        end
    endtask

    // ptr=0 on entry; leaves ptr=8, IDLE.
    task automatic test_alternate();
        logic [3:0] exp_seq [4] = '{4'd0, 4'd7, 4'd0, 4'd7};
        req = 16'h0081; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_idx !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL alternate[%0d]: valid=%b idx=%0d, required valid=1 idx=%0d",
                         i, out_valid, out_idx, exp_seq[i]);
            end
        end
        req = 16'h0000;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alternate_idle: valid=%b, required 0", out_valid);
        end
    endtask

    // ptr=8 on entry; search wraps to requester 2. Leaves ptr=3, IDLE.
    task automatic test_hold();
        req = 16'h0004; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) req = 16'h0000;
            n_cmp++;
            if (out_valid !== 1'b1 || out_idx !== 4'd2) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b idx=%0d, required valid=1 idx=2",
                         i, out_valid, out_idx);
            end
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_idx !== 4'd2) begin
            n_fail++;
            $display("FAIL hold_accept: valid=%b idx=%0d, required valid=0 idx=2",
                     out_valid, out_idx);
        end
    endtask

    // Grant 14 first so ptr=15, then 8001 grants 15 then wraps to 0. Leaves ptr=1, IDLE.
    task automatic test_wrap();
        logic [3:0] exp_seq [3] = '{4'd14, 4'd15, 4'd0};
        req = 16'h4000; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            req = 16'h8001;
            n_cmp++;
            if (out_valid !== 1'b1 || out_idx !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: valid=%b idx=%0d, required valid=1 idx=%0d",
                         i, out_valid, out_idx, exp_seq[i]);
            end
        end
        req = 16'h0000;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle: valid=%b, required 0", out_valid);
        end
    endtask

    // ptr=1 on entry. Leaves ptr=2, IDLE.
    task automatic test_reset_mid_grant();
        req = 16'h0010; out_ready = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== 4'd4) begin
            n_fail++;
            $display("FAIL pre_reset_grant: valid=%b idx=%0d, required valid=1 idx=4",
                     out_valid, out_idx);
        end
        rst = 1'b1; req = 16'hFFFF;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b idx=%0d, required valid=0 idx=0",
                     out_valid, out_idx);
        end
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_grant: valid=%b idx=%0d, required valid=1 idx=0",
                     out_valid, out_idx);
        end
        step();
        req = 16'h0000;
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== 4'd1) begin
            n_fail++;
            $display("FAIL post_reset_next: valid=%b idx=%0d, required valid=1 idx=1",
                     out_valid, out_idx);
        end
        step();
    endtask

    // A lone persistent requester is re-granted every cycle; 0x0A00 never grants others.
    task automatic test_back_to_back();
        req = 16'h0020; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_idx !== 4'd5) begin
                n_fail++;
                $display("FAIL single_req[%0d]: valid=%b idx=%0d, required valid=1 idx=5",
                         i, out_valid, out_idx);
            end
        end
        // ptr=6 at the next handshake: expect 9, 11, 9.
        req = 16'h0A00;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_idx !== ((i == 1) ? 4'd11 : 4'd9)) begin
                n_fail++;
                $display("FAIL sparse_req[%0d]: valid=%b idx=%0d, required valid=1 idx=%0d",
                         i, out_valid, out_idx, (i == 1) ? 11 : 9);
            end
        end
        req = 16'h0000;
        step();
    endtask

`ifdef RR_ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        rst = 1'b1; req = 16'h0000; out_ready = 1'b1;
        step();
        rst = 1'b0; req = 16'h0001;
        step();
        for (int i = 0; i < 19; i++) step();
        req = 16'h0000;
        step();
        n_cmp++;
        if (grant_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL grant_cnt: got %0d, required 20", grant_cnt);
        end
        req = 16'h0001;
        step();
        dut.grant_cnt_q = 16'hFFFF;
        req = 16'h0000;
        step();
        n_cmp++;
        if (grant_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL grant_cnt_wrap: got %0d, required 0", grant_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alternate();
        test_hold();
        test_wrap();
        test_reset_mid_grant();
        test_back_to_back();
`ifdef RR_ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_encoder.md
RR_ARB_ENCODER -- requirements
Module: rr_arb_encoder

Interface
REQ-001 SHALL have parameter encode_width, default 4, index width of the granted requester.
REQ-002 SHALL have parameter decode_width, default (1 << encode_width), number of request lines.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  decode_width  request lines, bit i = requester i.
REQ-006 SHALL have port out_ready  input  1  downstream decoder stage accepts out_idx.
REQ-007 SHALL have port out_valid  output  1  out_idx holds a valid grant.
REQ-008 SHALL have port out_idx  output  encode_width  binary index of the granted requester, fed to the downstream one-hot decoder.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (out_valid=0) and GRANT (out_valid=1).
REQ-010 SHALL keep an encode_width-bit round-robin pointer ptr; the search order is ptr, ptr+1, ..., decode_width-1, 0, ..., ptr-1.
REQ-011 In IDLE with req nonzero, SHALL load out_idx with the first set bit in search order and enter GRANT; out_valid rises the cycle after req is sampled (latency 1).
REQ-012 In IDLE with req zero, SHALL remain in IDLE with out_idx unchanged.
REQ-013 In GRANT with out_ready=0, SHALL hold out_valid and out_idx stable, ignoring req changes, including deassertion of the granted bit.
REQ-014 On handshake (out_valid && out_ready), SHALL set ptr to out_idx+1, wrapping modulo decode_width.
REQ-015 On handshake with req nonzero, SHALL load the next grant in the same cycle, searching from out_idx+1, and stay in GRANT, sustaining one grant per cycle.
REQ-016 On handshake with req zero, SHALL return to IDLE.
REQ-017 SHALL never grant a requester whose req bit was 0 in the selection cycle.
REQ-018 With a single persistent requester, SHALL re-grant it on every handshake.
REQ-019 Pointer arithmetic SHALL be encode_width bits wide with natural wrap; when decode_width < 2^encode_width, the pointer SHALL wrap from decode_width-1 to 0.

Reset
REQ-020 On rst=1 at a clock edge, SHALL force state=IDLE, out_valid=0, out_idx=0, ptr=0.
REQ-021 Reset SHALL take priority over handshake and selection; any pending grant is dropped without handshake.
REQ-022 On the first edge after rst deasserts, SHALL resume per REQ-011, with ptr=0.

Configuration
REQ-023 SHALL gate a grant counter with macro RR_ARB_GRANT_CNT_EN.
REQ-024 With RR_ARB_GRANT_CNT_EN defined, SHALL add output grant_cnt (16 bits), reset to 0, incremented by 1 per handshake, wrapping 0xFFFF->0.
REQ-025 Without RR_ARB_GRANT_CNT_EN, grant_cnt and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-026 SHALL place the FSM state typedef (IDLE, GRANT) and the default encode_width constant in shared package rr_arb_pkg.
REQ-027 SHALL implement selection in one combinational sub-module rr_pick (inputs req and start pointer; outputs found and idx); rr_arb_encoder contains only registers and the FSM.

Verification
REQ-028 Reset then req=16'h0000 for 5 cycles -> out_valid=0 and out_idx=0 throughout.
REQ-029 req=16'h0081, out_ready=1 held -> out_idx sequence 0, 7, 0, 7 with out_valid=1 from the cycle after req is applied.
REQ-030 req=16'h0004, out_ready=0 for 4 cycles, req dropped to 0 on cycle 2 -> out_valid=1, out_idx=2 stable; accepted when out_ready=1; then IDLE.
REQ-031 req=16'h8001 with ptr at 15 after a grant of 14 -> grant 15, then wrap to 0.
REQ-032 rst=1 asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and out_idx=0; with req=16'hFFFF held, first grant after reset is 0.
REQ-033 With RR_ARB_GRANT_CNT_EN defined, 20 handshakes -> grant_cnt=20; preload near 0xFFFF -> wraps to 0.
